// File: rtl/seg_pkg.sv
// seg_pkg: shared 7-segment table, blank pattern and decimal helpers
package seg_pkg;
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_TABLE [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                              8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    function automatic logic [7:0] seg_of(input logic [3:0] d);
        return d < 4'd10 ? SEG_TABLE[d] : SEG_BLANK;
    endfunction

    function automatic int pow10(input int n);
        int r = 1;
        for (int i = 0; i < n; i++) r *= 10;
        return r;
    endfunction
endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential shift-add-3 converter, VAL_W shifts then one done cycle
module bin2bcd_seq #(
    parameter int VAL_W  = 7,
    parameter int DIGITS = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [VAL_W-1:0]    bin,
    output logic                done,
    output logic [4*DIGITS-1:0] bcd,
    output logic                ovf
);
    import seg_pkg::*;
    localparam int CW = $clog2(VAL_W + 1);
    localparam logic [31:0] LIM = 32'(pow10(DIGITS));
    logic [4*DIGITS-1:0] acc, adj;
    logic [VAL_W-1:0] sh, src_sh;
    logic [CW-1:0] cnt;
    logic run;
    // start performs the first shift itself, seeding from bin
    always_comb begin
        adj = start ? '0 : acc;
        src_sh = start ? bin : sh;
        for (int d = 0; d < DIGITS; d++)
            adj[4*d +: 4] = adj[4*d +: 4] >= 4'd5 ? adj[4*d +: 4] + 4'd3 : adj[4*d +: 4];
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            run <= 1'b0;
            cnt <= '0;
            acc <= '0;
            sh <= '0;
            ovf <= 1'b0;
        end else if (start) begin
            {acc, sh} <= {adj, src_sh} << 1;
            cnt <= CW'(1);
            run <= 1'b1;
            ovf <= 32'(bin) >= LIM;
        end else if (run && cnt != CW'(VAL_W)) begin
            {acc, sh} <= {adj, src_sh} << 1;
            cnt <= cnt + 1'b1;
        end else
            run <= 1'b0;
    end
    assign done = run && cnt == CW'(VAL_W);
    assign bcd = ovf ? {DIGITS{4'd9}} : acc;
endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: multiplexed 7-segment scanner for NUM_FIELDS decimal fields
module seg_scan_driver #(
    parameter int NUM_FIELDS   = 3,
    parameter int DIGITS       = 2,
    parameter int VAL_W        = 7,
    parameter int SCAN_DIV     = 50000,
    parameter int COMMON_ANODE = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_FIELDS*VAL_W-1:0] val_in,
    input  logic                        load,
    input  logic [NUM_FIELDS-1:0]       blank_lz,
    output logic                        busy,
    output logic [NUM_FIELDS-1:0]       ovf,
    output logic [NUM_FIELDS*DIGITS-1:0] sel,
    output logic [7:0]                  seg
);
    import seg_pkg::*;
    localparam int N = NUM_FIELDS * DIGITS;
    localparam int BW = 4 * DIGITS;
    localparam int FW = NUM_FIELDS > 1 ? $clog2(NUM_FIELDS) : 1;
    localparam int IW = N > 1 ? $clog2(N) : 1;
    localparam int PW = $clog2(SCAN_DIV);
    localparam logic [7:0] OFF = COMMON_ANODE != 0 ? SEG_BLANK : ~SEG_BLANK;
    logic [NUM_FIELDS*VAL_W-1:0] vals;
    logic [NUM_FIELDS-1:0] blz_cap, disp_blz;
    logic [NUM_FIELDS*BW-1:0] stage, stage_nx, disp;
    logic [VAL_W-1:0] cur_val;
    logic [BW-1:0] bcd;
    logic [FW-1:0] fidx;
    logic [IW-1:0] idx;
    logic [PW-1:0] pre;
    logic [7:0] pat [N];
    logic kick, done, conv_ovf;

    bin2bcd_seq #(.VAL_W(VAL_W), .DIGITS(DIGITS)) u_conv (
        .clk(clk), .rst(rst), .start(kick), .bin(cur_val),
        .done(done), .bcd(bcd), .ovf(conv_ovf)
    );

    always_comb begin
        cur_val = '0;
        stage_nx = stage;
        for (int f = 0; f < NUM_FIELDS; f++)
            if (fidx == FW'(f)) begin
                cur_val = vals[f*VAL_W +: VAL_W];
                stage_nx[f*BW +: BW] = bcd;
            end
    end

    // results collect in stage; the visible frame swaps only when the last field lands
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0;
            kick <= 1'b0;
            fidx <= '0;
            ovf <= '0;
            vals <= '0;
            blz_cap <= '0;
            stage <= '0;
            disp <= '0;
            disp_blz <= '0;
        end else begin
            kick <= 1'b0;
            if (load && !busy) begin
                busy <= 1'b1;
                kick <= 1'b1;
                fidx <= '0;
                vals <= val_in;
                blz_cap <= blank_lz;
            end else if (done) begin
                stage <= stage_nx;
                ovf[fidx] <= conv_ovf;
                if (fidx == FW'(NUM_FIELDS - 1)) begin
                    busy <= 1'b0;
                    disp <= stage_nx;
                    disp_blz <= blz_cap;
                end else begin
                    kick <= 1'b1;
                    fidx <= fidx + 1'b1;
                end
            end
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_dig
        localparam int F = i / DIGITS;
        localparam int P = i % DIGITS;
        localparam int K = F * BW + 4 * (DIGITS - 1 - P);
        logic blank;
        logic [7:0] ca;
        assign blank = disp_blz[F] && P != DIGITS - 1 && disp[F*BW+BW-1 : K] == '0;
        assign ca = blank ? SEG_BLANK : seg_of(disp[K +: 4]) & (P == DIGITS - 1 ? 8'h7F : 8'hFF);
        assign pat[i] = COMMON_ANODE != 0 ? ca : ~ca;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre <= '0;
            idx <= '0;
            sel <= '1;
            seg <= OFF;
        end else begin
            pre <= pre == PW'(SCAN_DIV - 1) ? '0 : pre + 1'b1;
            if (pre == PW'(SCAN_DIV - 1)) idx <= idx == IW'(N - 1) ? '0 : idx + 1'b1;
            sel <= ~(N'(1) << idx);
            seg <= pat[idx];
        end
    end
endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: directed bench with a frame-level display model checked every cycle
module tb_seg_scan_driver;
    logic clk = 1'b0, rst = 1'b1, load = 1'b0;
    logic [20:0] val_in = '0;
    logic [2:0] blank_lz = '0;
    logic busy;
    logic [2:0] ovf;
    logic [5:0] sel;
    logic [7:0] seg;
    int n_chk = 0, n_pass = 0;
    bit chk_en = 1'b0;

    seg_scan_driver #(.NUM_FIELDS(3), .DIGITS(2), .VAL_W(7), .SCAN_DIV(4), .COMMON_ANODE(1)) dut (
        .clk(clk), .rst(rst), .val_in(val_in), .load(load), .blank_lz(blank_lz),
        .busy(busy), .ovf(ovf), .sel(sel), .seg(seg)
    );

    always #5 clk = ~clk;

    localparam logic [7:0] TAB [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                        8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // field value v, blanking b, digit position p (0 = tens, 1 = units)
    function automatic logic [7:0] exp_seg(input int v, input logic b, input int p);
        int x, d;
        logic [7:0] s;
        x = v > 99 ? 99 : v;
        d = p == 0 ? x / 10 : x % 10;
        if (p == 0 && b && d == 0) return 8'hFF;
        s = TAB[d];
        if (p == 1) s[7] = 1'b0;
        return s;
    endfunction

    // model: tk = non-reset edges since reset, rem = busy cycles left
    int rem = 0, tk = 0;
    int pend_v [3] = '{default: 0};
    int frame_v [3] = '{default: 0};
    int shown_v [3] = '{default: 0};
    logic [2:0] pend_b = '0, frame_b = '0, shown_b = '0, m_ovf = '0;

    always @(posedge clk) begin
        if (rst) begin
            rem <= 0;
            tk <= 0;
            m_ovf <= '0;
            frame_b <= '0;
            shown_b <= '0;
            for (int f = 0; f < 3; f++) begin
                frame_v[f] <= 0;
                shown_v[f] <= 0;
            end
        end else begin
            tk <= tk + 1;
            shown_b <= frame_b;
            for (int f = 0; f < 3; f++) shown_v[f] <= frame_v[f];
            if (rem == 0 && load) begin
                rem <= 24;
                pend_b <= blank_lz;
                for (int f = 0; f < 3; f++) pend_v[f] <= int'(val_in[f*7 +: 7]);
            end else if (rem > 0) begin
                rem <= rem - 1;
                if ((25 - rem) % 8 == 0) m_ovf[(25 - rem) / 8 - 1] <= pend_v[(25 - rem) / 8 - 1] > 99;
                if (rem == 1) begin
                    frame_b <= pend_b;
                    for (int f = 0; f < 3; f++) frame_v[f] <= pend_v[f];
                end
            end
        end
    end

    always @(negedge clk) begin
        int i;
        logic [5:0] es;
        logic [7:0] eg;
        if (chk_en) begin
            if (tk == 0) begin
                es = '1;
                eg = 8'hFF;
            end else begin
                i = ((tk - 1) / 4) % 6;
                es = ~(6'b1 << i);
                eg = exp_seg(shown_v[i / 2], shown_b[i / 2], i % 2);
            end
            chk("sel", 32'(sel), 32'(es));
            chk("seg", 32'(seg), 32'(eg));
            chk("busy", 32'(busy), 32'(rem != 0));
            chk("ovf", 32'(ovf), 32'(m_ovf));
        end
    end

    task automatic wait_sel(input logic [5:0] s, input logic [7:0] e, input string name);
        int n = 0;
        while (sel !== s && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (sel === s) chk(name, 32'(seg), 32'(e));
        else chk({name, "_timeout"}, 32'(sel), 32'(s));
    endtask

    task automatic do_load(input int v0, input int v1, input int v2, input logic [2:0] b,
                           input int extra_at, output int cyc);
        @(negedge clk);
        val_in = {7'(v2), 7'(v1), 7'(v0)};
        blank_lz = b;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        cyc = 0;
        while (busy && cyc < 100) begin
            cyc++;
            if (cyc == extra_at) begin
                val_in = '0;
                blank_lz = 3'b111;
                load = 1'b1;
            end else load = 1'b0;
            @(negedge clk);
        end
        load = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int cyc;
        @(posedge clk);
        #1 chk_en = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_sel", 32'(sel), 32'h3F);
        chk("rst_seg", 32'(seg), 32'hFF);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_ovf", 32'(ovf), 32'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("first_slot_sel", 32'(sel), 32'h3E);
        chk("first_slot_seg", 32'(seg), 32'hC0);

        do_load(12, 35, 5, 3'b000, 0, cyc);
        chk("busy_len", 32'(cyc), 32'd24);
        wait_sel(6'h3E, 8'hF9, "f0_tens");
        wait_sel(6'h3D, 8'h24, "f0_units");
        wait_sel(6'h2F, 8'hC0, "f2_tens");
        wait_sel(6'h1F, 8'h12, "f2_units");

        do_load(127, 35, 5, 3'b000, 0, cyc);
        chk("ovf_set", 32'(ovf), 32'h1);
        wait_sel(6'h3E, 8'h90, "sat_tens");
        wait_sel(6'h3D, 8'h10, "sat_units");
        do_load(7, 35, 5, 3'b000, 0, cyc);
        chk("ovf_clr", 32'(ovf), 32'h0);
        wait_sel(6'h3E, 8'hC0, "seven_tens");
        wait_sel(6'h3D, 8'h78, "seven_units");

        do_load(12, 35, 5, 3'b100, 0, cyc);
        wait_sel(6'h2F, 8'hFF, "blank_tens");
        wait_sel(6'h1F, 8'h12, "blank_units");
        wait_sel(6'h3E, 8'hF9, "noblank_f0");

        do_load(40, 67, 99, 3'b000, 5, cyc);
        chk("busy_len_ignored", 32'(cyc), 32'd24);
        wait_sel(6'h3E, 8'h99, "ign_f0_tens");
        wait_sel(6'h3D, 8'h40, "ign_f0_units");
        wait_sel(6'h3B, 8'h82, "ign_f1_tens");
        wait_sel(6'h2F, 8'h90, "ign_f2_tens");
        wait_sel(6'h1F, 8'h10, "ign_f2_units");
        chk("ovf_99", 32'(ovf), 32'h0);

        @(negedge clk);
        val_in = {7'd70, 7'd60, 7'd50};
        blank_lz = 3'b000;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_sel", 32'(sel), 32'h3F);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_slot_sel", 32'(sel), 32'h3E);
        chk("abort_slot_seg", 32'(seg), 32'hC0);
        wait_sel(6'h3D, 8'h40, "abort_d1");
        wait_sel(6'h3B, 8'hC0, "abort_d2");
        wait_sel(6'h37, 8'h40, "abort_d3");
        wait_sel(6'h2F, 8'hC0, "abort_d4");
        wait_sel(6'h1F, 8'h40, "abort_d5");
        repeat (30) @(negedge clk);
        chk("abort_no_commit", 32'(busy), 32'h0);

        do_load(0, 0, 0, 3'b111, 0, cyc);
        wait_sel(6'h3E, 8'hFF, "zero_tens_blank");
        wait_sel(6'h3D, 8'h40, "zero_units_lit");

        repeat (8) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
